// File: rtl/line_fetch_renderer.sv
// ---------------------------------------------------------------------------
// line_fetch_renderer
//
// Pixel back-end that sits directly behind the VGA timing generator.
//   * During each horizontal blank it prefetches the next visible line of a
//     4-bit-per-pixel framebuffer from external memory into a ping-pong line
//     buffer (bank = line number bit 0).
//   * It displays the current line from the other bank, maps each nibble
//     through a 16-entry programmable palette and drives registered RGB.
//   * Each pixel is held for 2 Clk cycles (50 MHz Clk, 25 MHz pixel rate), so
//     the 2-stage display pipeline delays video by exactly one pixel period.
//
// Ports
//   Clk, Reset           : system clock, synchronous active-high reset
//   DrawX, DrawY         : current pixel / line from the timing generator
//   VGA_BLANK_N          : active-low blank from the timing generator
//   mem_req, mem_addr    : word read request and its address
//   mem_ack, mem_rdata   : read completion and its data
//   pal_we/addr/data     : palette entry write port, data is {R,G,B}
//   VGA_R, VGA_G, VGA_B  : registered pixel colour
//   underrun             : sticky flag, a line was needed before it was ready
//
// Memory handshake: mem_req is a request-valid that stays high, with mem_addr
// stable, until the cycle in which mem_ack is high. That cycle transfers one
// word (mem_rdata valid). The next word's request follows in the next cycle
// with the incremented address. mem_ack outside a fetch is ignored.
// ---------------------------------------------------------------------------
module line_fetch_renderer #(
  parameter logic [18:0] FB_BASE        = 19'h00000,
  parameter int          WORDS_PER_LINE = 160,   // must be <= 256
  parameter int          ACTIVE_H       = 480,
  parameter int          V_TOTAL        = 525
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        VGA_BLANK_N,
  output logic        mem_req,
  output logic [18:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        pal_we,
  input  logic [3:0]  pal_addr,
  input  logic [23:0] pal_data,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        underrun
);

  // First blanked pixel column: 4 pixels per word.
  localparam logic [9:0] TRIG_X    = 10'(WORDS_PER_LINE * 4);
  localparam logic [7:0] LAST_WORD = 8'(WORDS_PER_LINE - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // ------------------------------------------------------------------------
  // Trigger and target-line selection
  // ------------------------------------------------------------------------
  logic [9:0]  drawx_q;
  logic        trigger;
  logic [9:0]  next_line;
  logic        next_valid;
  logic [18:0] line_base;

  always_ff @(posedge Clk) begin
    if (Reset) drawx_q <= 10'd0;
    else       drawx_q <= DrawX;
  end

  // DrawX sits at 640 for two Clk cycles; fire only on the first of them.
  assign trigger = (DrawX == TRIG_X) && (drawx_q != TRIG_X);

  always_comb begin
    next_line  = 10'd0;
    next_valid = 1'b0;
    if (DrawY < 10'(ACTIVE_H - 1)) begin
      next_line  = DrawY + 10'd1;
      next_valid = 1'b1;
    end else if (DrawY == 10'(V_TOTAL - 1)) begin
      // Last line of the frame prefetches line 0 of the next frame.
      next_line  = 10'd0;
      next_valid = 1'b1;
    end
  end

  assign line_base = FB_BASE + ({9'd0, next_line} * 19'(WORDS_PER_LINE));

  // ------------------------------------------------------------------------
  // Fetch FSM: state register / next state / outputs
  // ------------------------------------------------------------------------
  logic [9:0]  tgt_line_q;
  logic [7:0]  word_cnt_q;
  logic [18:0] addr_q;
  logic        last_word;
  logic        start_fetch;
  logic        word_accept;
  logic        fetch_done;
  logic        late_trigger;
  logic        req_c;

  assign last_word = (word_cnt_q == LAST_WORD);

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trigger && next_valid)  state_d = FETCH;
      FETCH:   if (mem_ack && last_word)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_c        = 1'b0;
    start_fetch  = 1'b0;
    word_accept  = 1'b0;
    fetch_done   = 1'b0;
    late_trigger = 1'b0;
    case (state_q)
      IDLE: begin
        start_fetch = trigger && next_valid;
      end
      FETCH: begin
        req_c        = 1'b1;
        word_accept  = mem_ack;
        fetch_done   = mem_ack && last_word;
        // The line after this one is due now but the fetch is still busy.
        late_trigger = trigger;
      end
      default: ;
    endcase
  end

  assign mem_req  = req_c;
  assign mem_addr = addr_q;

  // Fetch datapath: target line, word counter and request address.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tgt_line_q <= 10'd0;
      word_cnt_q <= 8'd0;
      addr_q     <= 19'd0;
    end else if (start_fetch) begin
      tgt_line_q <= next_line;
      word_cnt_q <= 8'd0;
      addr_q     <= line_base;
    end else if (word_accept && !last_word) begin
      word_cnt_q <= word_cnt_q + 8'd1;
      addr_q     <= addr_q + 19'd1;
    end
  end

  // ------------------------------------------------------------------------
  // Bank completion marks and underrun detection
  // ------------------------------------------------------------------------
  logic [9:0] done_line_q [0:1];
  logic [1:0] done_valid_q;
  logic       armed_q;
  logic       underrun_q;
  logic       line_start;
  logic       line_ready;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      done_line_q[0] <= 10'd0;
      done_line_q[1] <= 10'd0;
      done_valid_q   <= 2'b00;
      armed_q        <= 1'b0;
    end else begin
      // A bank being refilled no longer holds a complete line.
      if (start_fetch) done_valid_q[next_line[0]] <= 1'b0;
      if (fetch_done) begin
        done_valid_q[tgt_line_q[0]] <= 1'b1;
        done_line_q[tgt_line_q[0]]  <= tgt_line_q;
        // Checking starts only once the pipeline is primed with line 0.
        if (tgt_line_q == 10'd0) armed_q <= 1'b1;
      end
    end
  end

  assign line_start = (DrawX == 10'd0) && (drawx_q != 10'd0) &&
                      (DrawY < 10'(ACTIVE_H));
  assign line_ready = done_valid_q[DrawY[0]] &&
                      (done_line_q[DrawY[0]] == DrawY);

  always_ff @(posedge Clk) begin
    if (Reset) underrun_q <= 1'b0;
    else       underrun_q <= underrun_q | late_trigger |
                             (armed_q & line_start & ~line_ready);
  end

  assign underrun = underrun_q;

  // ------------------------------------------------------------------------
  // Ping-pong line buffer (not reset) and display stage 1 read.
  // Depth 256 so any DrawX[9:2] (up to 199 in blank) is a legal index.
  // ------------------------------------------------------------------------
  logic [15:0] line_buf [0:1][0:255];
  logic [15:0] s1_word_q;

  always_ff @(posedge Clk) begin
    if (word_accept && !Reset)
      line_buf[tgt_line_q[0]][word_cnt_q] <= mem_rdata;
    s1_word_q <= line_buf[DrawY[0]][DrawX[9:2]];
  end

  // ------------------------------------------------------------------------
  // Palette: reset to a grayscale ramp; writes land on the next edge, so a
  // same-cycle lookup of the entry being written sees the old colour.
  // ------------------------------------------------------------------------
  logic [23:0] palette [0:15];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) palette[i] <= {3{8'(8'h11 * i)}};
    end else if (pal_we) begin
      palette[pal_addr] <= pal_data;
    end
  end

  // ------------------------------------------------------------------------
  // Display stages 1 (control) and 2 (nibble select, palette, blank)
  // ------------------------------------------------------------------------
  logic [1:0]  s1_sel_q;
  logic        s1_blank_n_q;
  logic [3:0]  pix_nib;
  logic [23:0] rgb_q;

  assign pix_nib = s1_word_q[{s1_sel_q, 2'b00} +: 4];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_sel_q     <= 2'd0;
      s1_blank_n_q <= 1'b0;
      rgb_q        <= 24'h0;
    end else begin
      s1_sel_q     <= DrawX[1:0];
      s1_blank_n_q <= VGA_BLANK_N;
      rgb_q        <= s1_blank_n_q ? palette[pix_nib] : 24'h0;
    end
  end

  assign VGA_R = rgb_q[23:16];
  assign VGA_G = rgb_q[15:8];
  assign VGA_B = rgb_q[7:0];

endmodule

// File: tb/tb_line_fetch_renderer.sv
// Bench for line_fetch_renderer. Lines are abbreviated: DrawX/DrawY are
// driven only over the columns that matter, since the design reacts to the
// values it sees rather than to a continuous raster.
module tb_line_fetch_renderer;

  localparam int FB_BASE = 0;
  localparam int WPL     = 160;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic        blank_n;
  logic        mem_req;
  logic [18:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [23:0] pal_data;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        underrun;
  logic [23:0] rgb;

  always #10 clk = ~clk;

  assign rgb = {vga_r, vga_g, vga_b};

  line_fetch_renderer dut (
    .Clk         (clk),
    .Reset       (reset),
    .DrawX       (draw_x),
    .DrawY       (draw_y),
    .VGA_BLANK_N (blank_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .pal_we      (pal_we),
    .pal_addr    (pal_addr),
    .pal_data    (pal_data),
    .VGA_R       (vga_r),
    .VGA_G       (vga_g),
    .VGA_B       (vga_b),
    .underrun    (underrun)
  );

  // ---------------- scoreboard / reference model ----------------
  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 1;
  int          req_cyc;
  logic [18:0] addr_log [$];
  logic [15:0] fb_mem [int];
  logic [23:0] pal_model [16];
  logic [23:0] exp_q [$];

  function automatic logic [15:0] fb_read(int a);
    if (!fb_mem.exists(a)) fb_mem[a] = 16'($urandom);
    return fb_mem[a];
  endfunction

  // Colour that should be on screen for pixel (x,y) of a fetched line.
  function automatic logic [23:0] exp_px(int y, int x, logic bn);
    logic [15:0] w;
    int          nib;
    if (!bn) return 24'h0;
    w   = fb_read(FB_BASE + y * WPL + x / 4);
    nib = (int'(w) >> (4 * (x % 4))) & 15;
    return pal_model[nib];
  endfunction

  function automatic void pal_model_reset();
    for (int i = 0; i < 16; i++) pal_model[i] = {3{8'(17 * i)}};
  endfunction

  // ---------------- memory model ----------------
  // Acks each word on the mem_lat-th cycle it has been requested.
  initial begin
    int cnt;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req === 1'b1) begin
        if (cnt >= mem_lat - 1) begin
          mem_ack   = 1'b1;
          mem_rdata = fb_read(int'(mem_addr));
          addr_log.push_back(mem_addr);
          cnt = 0;
        end else begin
          mem_ack = 1'b0;
          cnt++;
        end
      end else begin
        mem_ack = 1'b0;
        cnt     = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic show(input int x, input int y);
    draw_x = 10'(x);
    draw_y = 10'(y);
  endtask

  task automatic wait_req_low(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (mem_req === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    if (mem_req === 1'b0) ok = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset   = 1'b1;
    blank_n = 1'b1;
    pal_we  = 1'b0;
    pal_addr = 4'h0;
    pal_data = 24'h0;
    show(0, 0);
    tick(3);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", mem_req); end
    checks++; if (mem_addr !== 19'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", mem_addr); end
    checks++; if (rgb !== 24'h0) begin errors++; $display("FAIL reset_rgb got %h want 000000", rgb); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", underrun); end
    reset = 1'b0;
    pal_model_reset();
    tick(1);
  endtask

  task automatic test_first_fetch;
    bit ok;
    mem_lat = 1;
    // Line 523 is in vertical blank and does not precede a visible line.
    show(639, 523); tick(2);
    show(640, 523); tick(2);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL nofetch_523 req got %b want 0", mem_req); end
    show(639, 524); tick(2);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL prefetch_idle req got %b want 0", mem_req); end
    addr_log.delete();
    show(640, 524); tick(1);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL fetch0_start req got %b want 1", mem_req); end
    checks++; if (mem_addr !== 19'(FB_BASE)) begin errors++; $display("FAIL fetch0_addr got %0d want %0d", mem_addr, FB_BASE); end
    wait_req_low(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fetch0_timeout req still %b want 0", mem_req); end
    checks++; if (addr_log.size() != WPL) begin errors++; $display("FAIL fetch0_count got %0d want %0d", addr_log.size(), WPL); end
    for (int i = 0; i < addr_log.size(); i++) begin
      checks++;
      if (addr_log[i] !== 19'(FB_BASE + i)) begin
        errors++; $display("FAIL fetch0_seq[%0d] got %0d want %0d", i, addr_log[i], FB_BASE + i);
      end
    end
    // Start of line 0: its bank is complete, so no underrun.
    show(0, 0); tick(2);
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL line0_start underrun got %b want 0", underrun); end
    show(639, 0); tick(2);
    addr_log.delete();
    show(640, 0); tick(1);
    checks++; if (mem_addr !== 19'(FB_BASE + WPL)) begin errors++; $display("FAIL fetch1_addr got %0d want %0d", mem_addr, FB_BASE + WPL); end
    wait_req_low(400, ok);
    checks++; if (!ok || addr_log.size() != WPL) begin errors++; $display("FAIL fetch1_done words %0d want %0d", addr_log.size(), WPL); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL fetch1_underrun got %b want 0", underrun); end
  endtask

  task automatic test_display;
    logic [23:0] want;
    logic [23:0] prev;
    int          x;
    int          y;
    prev  = 24'h0;
    exp_q = {24'h111111, 24'h222222, 24'h333333, 24'h444444};
    for (int i = 0; i < 4; i++) begin
      want = exp_q.pop_front();
      show(i, 1); tick(1);
      if (i > 0) begin
        checks++; if (rgb !== prev) begin errors++; $display("FAIL px_hold x=%0d got %h want %h", i, rgb, prev); end
      end
      tick(1);
      checks++; if (rgb !== want) begin errors++; $display("FAIL px_4321 x=%0d got %h want %h", i, rgb, want); end
      prev = want;
    end
    for (int k = 0; k < 10; k++) begin
      y = int'($urandom_range(0, 1));
      x = int'($urandom_range(1, 639));
      show(x, y); tick(2);
      want = exp_px(y, x, 1'b1);
      checks++; if (rgb !== want) begin errors++; $display("FAIL px_rand y=%0d x=%0d got %h want %h", y, x, rgb, want); end
    end
  endtask

  task automatic test_palette;
    logic [23:0] want;
    logic [3:0]  idx;
    logic [23:0] val;
    int          x;
    // Pixel 5 of line 1 holds index F.
    show(5, 1); tick(1);
    pal_we = 1'b1; pal_addr = 4'hF; pal_data = 24'hFF0000;
    tick(1);
    pal_we = 1'b0;
    checks++; if (rgb !== 24'hFFFFFF) begin errors++; $display("FAIL pal_old got %h want ffffff", rgb); end
    tick(1);
    pal_model[15] = 24'hFF0000;
    checks++; if (rgb !== 24'hFF0000) begin errors++; $display("FAIL pal_red got %h want ff0000", rgb); end
    checks++; if (vga_r !== 8'hFF) begin errors++; $display("FAIL pal_red_r got %h want ff", vga_r); end
    blank_n = 1'b0; tick(2);
    checks++; if (rgb !== 24'h0) begin errors++; $display("FAIL blank_out got %h want 000000", rgb); end
    blank_n = 1'b1; tick(2);
    for (int k = 0; k < 6; k++) begin
      idx = 4'($urandom_range(0, 15));
      val = 24'($urandom);
      pal_we = 1'b1; pal_addr = idx; pal_data = val;
      tick(1);
      pal_we = 1'b0;
      pal_model[idx] = val;
      x = int'($urandom_range(0, 639));
      show(x, 1); tick(2);
      want = exp_px(1, x, 1'b1);
      checks++; if (rgb !== want) begin errors++; $display("FAIL pal_rand x=%0d got %h want %h", x, rgb, want); end
    end
  endtask

  task automatic test_no_fetch_blank;
    int          ys [4] = '{479, 480, 500, 523};
    bit          ok;
    int          x;
    logic [23:0] want;
    foreach (ys[i]) begin
      show(639, ys[i]); tick(2);
      show(640, ys[i]); tick(2);
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL nofetch y=%0d req got %b want 0", ys[i], mem_req); end
    end
    show(639, 478); tick(2);
    addr_log.delete();
    show(640, 478); tick(1);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 19'(FB_BASE + 76640)) begin
      errors++; $display("FAIL fetch479_addr req %b addr %0d want 1 %0d", mem_req, mem_addr, FB_BASE + 76640);
    end
    wait_req_low(400, ok);
    checks++; if (!ok || addr_log.size() != WPL) begin errors++; $display("FAIL fetch479_done words %0d want %0d", addr_log.size(), WPL); end
    checks++; if (addr_log.size() > 0 && addr_log[addr_log.size()-1] !== 19'(FB_BASE + 76799)) begin
      errors++; $display("FAIL fetch479_last got %0d want %0d", addr_log[addr_log.size()-1], FB_BASE + 76799);
    end
    for (int k = 0; k < 5; k++) begin
      x = (k == 0) ? 0 : int'($urandom_range(1, 639));
      show(x, 479); tick(2);
      want = exp_px(479, x, 1'b1);
      checks++; if (rgb !== want) begin errors++; $display("FAIL bank1_px x=%0d got %h want %h", x, rgb, want); end
    end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL line479_underrun got %b want 0", underrun); end
  endtask

  task automatic test_underrun_display;
    // Line 100 was never fetched; its first pixel must flag underrun.
    show(5, 100); tick(2);
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_pre got %b want 0", underrun); end
    show(0, 100); tick(1);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_missing_line got %b want 1", underrun); end
    show(8, 100); tick(4);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky got %b want 1", underrun); end
  endtask

  task automatic test_reset_mid_fetch;
    bit          ok;
    int          x;
    logic [23:0] want;
    mem_lat = 1;
    show(639, 10); tick(2);
    addr_log.delete();
    show(640, 10);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick(1);
      if (mem_addr === 19'(FB_BASE + 1760 + 80)) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL mid_reach addr %0d want %0d", mem_addr, FB_BASE + 1840); end
    reset = 1'b1; tick(1);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_reset_req got %b want 0", mem_req); end
    checks++; if (mem_addr !== 19'd0) begin errors++; $display("FAIL mid_reset_addr got %0d want 0", mem_addr); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL mid_reset_underrun got %b want 0", underrun); end
    reset = 1'b0;
    pal_model_reset();
    show(641, 10); tick(2);
    show(639, 10); tick(2);
    addr_log.delete();
    show(640, 10); tick(1);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 19'(FB_BASE + 1760)) begin
      errors++; $display("FAIL restart_addr req %b addr %0d want 1 %0d", mem_req, mem_addr, FB_BASE + 1760);
    end
    wait_req_low(400, ok);
    checks++; if (!ok || addr_log.size() != WPL) begin errors++; $display("FAIL restart_words got %0d want %0d", addr_log.size(), WPL); end
    checks++; if (addr_log.size() > 0 && addr_log[addr_log.size()-1] !== 19'(FB_BASE + 1919)) begin
      errors++; $display("FAIL restart_last got %0d want %0d", addr_log[addr_log.size()-1], FB_BASE + 1919);
    end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL restart_underrun got %b want 0", underrun); end
    for (int k = 0; k < 4; k++) begin
      x = int'($urandom_range(0, 639));
      show(x, 11); tick(2);
      want = exp_px(11, x, 1'b1);
      checks++; if (rgb !== want) begin errors++; $display("FAIL line11_px x=%0d got %h want %h", x, rgb, want); end
    end
  endtask

  task automatic test_underrun_latency;
    bit ok;
    mem_lat = 12;
    show(639, 20); tick(2);
    addr_log.delete();
    req_cyc = 0;
    show(640, 20); tick(1);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 19'(FB_BASE + 3360)) begin
      errors++; $display("FAIL slow_start req %b addr %0d want 1 %0d", mem_req, mem_addr, FB_BASE + 3360);
    end
    if (mem_req === 1'b1) req_cyc++;
    tick(1); if (mem_req === 1'b1) req_cyc++;
    for (int x = 641; x < 800; x++) begin
      show(x, 20);
      repeat (2) begin tick(1); if (mem_req === 1'b1) req_cyc++; end
    end
    for (int x = 0; x < 640; x++) begin
      show(x, 21);
      repeat (2) begin tick(1); if (mem_req === 1'b1) req_cyc++; end
    end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL slow_pre got %b want 0", underrun); end
    show(640, 21); tick(1);
    if (mem_req === 1'b1) req_cyc++;
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL slow_underrun got %b want 1", underrun); end
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      tick(1);
      if (mem_req === 1'b1) req_cyc++;
      else begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL slow_timeout req still %b want 0", mem_req); end
    checks++; if (req_cyc != 1920) begin errors++; $display("FAIL slow_cycles got %0d want 1920", req_cyc); end
    checks++; if (addr_log.size() != WPL) begin errors++; $display("FAIL slow_words got %0d want %0d", addr_log.size(), WPL); end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1500000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence + report ----------------
  initial begin
    reset = 1'b1;
    blank_n = 1'b1;
    pal_we = 1'b0;
    pal_addr = 4'h0;
    pal_data = 24'h0;
    draw_x = 10'd0;
    draw_y = 10'd0;
    fb_mem[FB_BASE + 160] = 16'h4321;
    fb_mem[FB_BASE + 161] = 16'h00F0;
    test_reset();
    test_first_fetch();
    test_display();
    test_palette();
    test_no_fetch_blank();
    test_underrun_display();
    test_reset_mid_fetch();
    test_underrun_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
